uart_frame_master: RTL
======================

# uart_frame_master

Host-side initiator for the 115200-baud, 8N1 word-framed UART link used by the Avalon UART peripheral. On a start request it serializes a 5-byte command frame (4 data bytes LSB-first, then a control byte carrying 2 control bits) onto TX. When a reply is expected, it then collects a 4-byte response word from RX. It is the peer of the peripheral-side frame receiver/transmitter and is used in the testbench and host-bridge FPGA images.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CLKS, 43400: response timeout in cycles; used only with the timeout feature.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle transaction request; accepted only while busy=0.
- cmd_data  in  32  command word; byte 0 = [7:0] sent first.
- cmd_ctrl  in  2  control bits; sent as byte 4 = {6'b0, cmd_ctrl}.
- expect_rsp  in  1  1 = wait for a 4-byte reply after the frame.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- rsp_valid  out  1  one-cycle pulse, coincident with done, when a full reply was received.
- rsp_data  out  32  reply word; first received byte in [7:0]. Holds its value until the next valid reply.
- timeout  out  1  one-cycle pulse, coincident with done, on reply timeout.
- frm_err  out  1  one-cycle pulse on a reply byte with a low stop bit.
- TX  out  1  serial output; idle high.
- RX  in  1  serial input; passes through a 2-flop synchronizer before use.

## Operation
- Reset values: TX=1, busy=0, done=0, rsp_valid=0, timeout=0, frm_err=0, rsp_data=0, FSM=IDLE.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
- IDLE → SEND on start=1:
  - Latch cmd_data, cmd_ctrl and expect_rsp.
  - Set byte index to 0.
- start while busy=1 is ignored. Latched values are not affected by later input changes.
- SEND, per byte:
  - Start bit (0), then 8 data bits LSB-first, then stop bit (1), each held exactly CLKS_PER_BIT cycles.
  - The next start bit follows the stop bit immediately, with no extra idle time.
- After the byte-4 stop bit completes:
  - expect_rsp=1 → WAIT_RSP, reply index 0.
  - expect_rsp=0 → DONE.
- Receiver behaviour:
  - Runs continuously.
  - A falling edge on the synchronized RX starts a byte.
  - The start bit is re-checked at CLKS_PER_BIT/2; if RX is high again, the byte is aborted silently.
  - Data bits and the stop bit are sampled at bit centers.
- In WAIT_RSP:
  - Each good byte is written to rsp_data byte lane[index], and the index increments.
  - After index 3 → DONE with rsp_valid=1.
  - A byte with a low stop bit pulses frm_err, is discarded, and does not advance the index.
- Bytes received outside WAIT_RSP are discarded, and frm_err is not pulsed.
- DONE lasts one cycle: done=1, then → IDLE.
- rsp_data lanes are staged internally; rsp_data updates atomically in the DONE cycle, and only on success.

## Timing
- TX start bit begins on the cycle after start is sampled. busy rises in that same cycle.
- A frame without a reply lasts 50×CLKS_PER_BIT cycles from start acceptance to the DONE cycle. done asserts on cycle 50×CLKS_PER_BIT+1.
- With a reply, rsp_valid/done assert 1 cycle after the center-sample of the 4th reply byte's stop bit.
- busy falls on the cycle after DONE. A new start is accepted in that cycle.
- An RX edge during the SEND→WAIT_RSP transition cycle is treated as belonging to WAIT_RSP.
- Asynchronous reset mid-frame forces TX=1 immediately and clears all partial state.

## Configuration
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - In WAIT_RSP, a counter starts at 0 and is cleared on each receiver start-bit detection.
  - When the counter reaches TIMEOUT_CLKS → DONE with timeout=1 and rsp_valid=0.
  - Partial bytes are discarded and rsp_data is unchanged.
- Undefined:
  - No counter; WAIT_RSP waits indefinitely.
  - timeout is tied to 0 and TIMEOUT_CLKS is ignored.

## Test plan
Benches run with CLKS_PER_BIT=8.
- Reset: RST pulse mid-SEND → TX=1 within the same cycle, busy=0, and no done after release.
- No-reply frame: start with cmd_data=0xA1B2C3D4, cmd_ctrl=2'b10, expect_rsp=0.
  - TX bytes D4,C3,B2,A1,02, each 8N1.
  - done at cycle 401 after start; rsp_valid=0.
- Reply frame: expect_rsp=1; the bench model replies 0x11,0x22,0x33,0x44.
  - rsp_valid=1 with rsp_data=0x44332211.
- Framing error: the 2nd reply byte has stop=0.
  - frm_err pulses once; that byte is discarded.
  - The next 3 good bytes complete the reply.
- Busy and stray traffic: start pulses during SEND are ignored, and exactly one frame is sent. RX bytes received in IDLE do not alter rsp_data.
- Timeout (UART_FRAME_TIMEOUT_EN defined, TIMEOUT_CLKS=200): only 2 reply bytes are sent.
  - timeout=done=1 and rsp_valid=0.
  - rsp_data keeps its prior value.

Source files
------------

// File: rtl/uart_frame_master.sv
// Host-side 8N1 UART frame initiator: 5-byte command out, optional 4-byte reply in.
// Optional reply timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_master #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] cmd_data,
    input  logic [1:0]  cmd_ctrl,
    input  logic        expect_rsp,
    output logic        busy,
    output logic        done,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        timeout,
    output logic        frm_err,
    output logic        TX,
    input  logic        RX
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rstate_t;

    state_t  r_state;
    state_t  w_next;
    rstate_t r_rstate;
    rstate_t w_rnext;

    logic [31:0]   r_data;
    logic [1:0]    r_ctrl;
    logic          r_exp;
    logic [2:0]    r_byte;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_tcnt;

    logic [7:0] w_cur_byte;
    logic [2:0] w_didx;
    logic       w_tx_bit;
    logic       w_bit_end;
    logic       w_byte_end;
    logic       w_frame_end;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_d;
    logic [CW-1:0] r_rcnt;
    logic [2:0]    r_rbit;
    logic [7:0]    r_rsh;
    logic          w_fall;
    logic          w_rx_start;
    logic          w_rx_ok;
    logic          w_rx_err;

    logic [1:0]  r_ridx;
    logic [23:0] r_stage;
    logic [31:0] r_rsp;
    logic        r_ok;
    logic        w_last_ok;
    logic        w_to_hit;

    // Command serializer
    assign w_bit_end   = (r_tcnt == LAST);
    assign w_byte_end  = w_bit_end && (r_bit == 4'd9);
    assign w_frame_end = w_byte_end && (r_byte == 3'd4);

    always_comb begin
        w_cur_byte = {6'b0, r_ctrl};
        case (r_byte)
            3'd0:    w_cur_byte = r_data[7:0];
            3'd1:    w_cur_byte = r_data[15:8];
            3'd2:    w_cur_byte = r_data[23:16];
            3'd3:    w_cur_byte = r_data[31:24];
            default: w_cur_byte = {6'b0, r_ctrl};
        endcase
        w_didx   = 3'(r_bit - 4'd1);
        w_tx_bit = 1'b1;
        if (r_bit == 4'd0) begin
            w_tx_bit = 1'b0;
        end else if (r_bit <= 4'd8) begin
            w_tx_bit = w_cur_byte[w_didx];
        end
    end

    assign TX = (r_state == SEND) ? w_tx_bit : 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data <= '0;
            r_ctrl <= '0;
            r_exp  <= 1'b0;
            r_byte <= '0;
            r_bit  <= '0;
            r_tcnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_data <= cmd_data;
            r_ctrl <= cmd_ctrl;
            r_exp  <= expect_rsp;
            r_byte <= '0;
            r_bit  <= '0;
            r_tcnt <= '0;
        end else if (r_state == SEND) begin
            if (w_bit_end) begin
                r_tcnt <= '0;
                if (r_bit == 4'd9) begin
                    r_bit  <= '0;
                    r_byte <= r_byte + 3'd1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    // Receiver: 2-flop synchronizer, then free-running byte deframer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_fall = r_rx_d && !r_rx_s2;

    always_comb begin
        w_rnext    = r_rstate;
        w_rx_start = 1'b0;
        w_rx_ok    = 1'b0;
        w_rx_err   = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (w_fall) begin
                    w_rnext    = R_START;
                    w_rx_start = 1'b1;
                end
            end
            R_START: begin
                if (r_rcnt == HALF) begin
                    w_rnext = r_rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_rcnt == LAST && r_rbit == 3'd7) begin
                    w_rnext = R_STOP;
                end
            end
            R_STOP: begin
                if (r_rcnt == LAST) begin
                    w_rnext  = R_IDLE;
                    w_rx_ok  = r_rx_s2;
                    w_rx_err = !r_rx_s2;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= '0;
            r_rbit   <= '0;
            r_rsh    <= '0;
        end else begin
            r_rstate <= w_rnext;
            unique case (r_rstate)
                R_IDLE: begin
                    r_rcnt <= '0;
                    r_rbit <= '0;
                end
                R_START: begin
                    r_rcnt <= (r_rcnt == HALF) ? '0 : r_rcnt + 1'b1;
                end
                R_DATA: begin
                    if (r_rcnt == LAST) begin
                        r_rcnt <= '0;
                        r_rbit <= r_rbit + 3'd1;
                        r_rsh  <= {r_rx_s2, r_rsh[7:1]};
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                R_STOP: begin
                    r_rcnt <= (r_rcnt == LAST) ? '0 : r_rcnt + 1'b1;
                end
                default: r_rcnt <= '0;
            endcase
        end
    end

    // Reply timeout
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_to;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_to_cnt <= '0;
        end else if (r_state != WAIT_RSP || w_rx_start) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TW'(TIMEOUT_CLKS)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_state == WAIT_RSP) &&
                      (r_to_cnt == TW'(TIMEOUT_CLKS));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_to <= 1'b0;
        end else if (w_next == DONE && r_state != DONE) begin
            r_to <= (r_state == WAIT_RSP) && !w_last_ok;
        end
    end

    assign timeout = (r_state == DONE) && r_to;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Transaction FSM
    assign w_last_ok = (r_state == WAIT_RSP) && w_rx_ok &&
                       (r_ridx == 2'd3);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = SEND;
            end
            SEND: begin
                if (w_frame_end) w_next = r_exp ? WAIT_RSP : DONE;
            end
            WAIT_RSP: begin
                if (w_last_ok || w_to_hit) w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Reply lanes stage until the 4th byte so rsp_data changes in one step
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ridx  <= '0;
            r_stage <= '0;
            r_rsp   <= '0;
            r_ok    <= 1'b0;
        end else begin
            if (r_state == SEND) begin
                r_ridx <= '0;
            end else if (r_state == WAIT_RSP && w_rx_ok) begin
                unique case (r_ridx)
                    2'd0: r_stage[7:0]   <= r_rsh;
                    2'd1: r_stage[15:8]  <= r_rsh;
                    2'd2: r_stage[23:16] <= r_rsh;
                    2'd3: r_rsp          <= {r_rsh, r_stage};
                    default: r_stage     <= r_stage;
                endcase
                r_ridx <= r_ridx + 2'd1;
            end
            if (w_next == DONE && r_state != DONE) begin
                r_ok <= w_last_ok;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign rsp_valid = (r_state == DONE) && r_ok;
    assign rsp_data  = r_rsp;
    assign frm_err   = (r_state == WAIT_RSP) && w_rx_err;

endmodule
